fetch_ctrl: RTL
===============

// Module: fetch_ctrl
// PURPOSE
// - Sequencer for the 2-wide fetch stage: owns the fetch PC and drives the fetch address each cycle.
// - Tags each fetch-register slot with a valid bit and stalls on decode backpressure.
// - Squashes wrong-path fetches on redirect (branch/flush) and halts at end of instruction memory.
// - Sits between the backend (redirect source), the fetch stage (pc consumer) and decode (dec_ready).
// PARAMETERS
// - RESET_PC    32'h0000_0000  fetch address loaded on reset
// - IMEM_BYTES  128            byte size of instruction ROM; addresses >= IMEM_BYTES are invalid
// - CNT_W       16             width of the saturating performance counters
// PORTS
// - clk             in   1      clock, rising-edge
// - rst             in   1      reset, asynchronous, active-high
// - start           in   1      leave IDLE and begin fetching at pc_q
// - dec_ready       in   1      decode accepts the current fetch-register pair this cycle
// - redirect_valid  in   1      redirect fetch (branch mispredict / flush)
// - redirect_pc     in   32     redirect target; bits [1:0] are forced to 0
// - pc              out  32     fetch address to fetch stage (slot a = pc, slot b = pc+4)
// - fd_valid_a      out  1      fetch register slot a holds a valid instruction
// - fd_valid_b      out  1      fetch register slot b holds a valid instruction
// - fd_pc           out  32     address of the pair currently held in the fetch register
// - halted          out  1      state == HALT
// - fetch_cnt       out  CNT_W  instructions accepted by decode, saturating
// - stall_cnt       out  CNT_W  cycles with fd_valid_a=1 and dec_ready=0, saturating
// BEHAVIOUR
// - Reset (async): state=IDLE, pc_q=RESET_PC, fd_pc_q=RESET_PC, fd_valid_a/b=0, both counters=0.
// - Fetch-register latency: 1 cycle. Pair for address P is in the fetch register the cycle after pc==P.
// - hold   = fd_valid_a & ~dec_ready   (combinational)
// - pc     = hold ? fd_pc_q : pc_q     (combinational; re-fetching the same pair keeps the fetch register stable)
// - fd_pc  = fd_pc_q
// - States: IDLE, RUN, STALL, HALT. Priority per edge: redirect > hold > advance.
//   - IDLE:    start=1 -> RUN. redirect_valid is ignored. Valids stay 0.
//   - redirect_valid (RUN/STALL/HALT):
//     - pc_q <= {redirect_pc[31:2],2'b00}; fd_valid_a/b <= 0 (squashes the in-flight wrong-path pair).
//     - Next state: RUN. A pair held by hold is discarded and is not counted.
//   - hold (RUN/STALL), no redirect: pc_q, fd_pc_q and valids unchanged; state=STALL; stall_cnt += 1.
//   - advance (RUN/STALL), no redirect, no hold:
//     - fd_pc_q <= pc_q; fd_valid_a <= (pc_q < IMEM_BYTES); fd_valid_b <= (pc_q+4 < IMEM_BYTES).
//     - If pc_q < IMEM_BYTES: pc_q <= pc_q+8, state=RUN. Otherwise pc_q holds and state=HALT.
//   - HALT: valids go to 0 once decode accepts the pair (or immediately if none is valid).
//     - Stays in HALT until redirect_valid is asserted.
// - fetch_cnt += (fd_valid_a & dec_ready) + (fd_valid_b & dec_ready) on any edge without redirect.
// - Counters saturate at all-ones. Compare arithmetic uses 33 bits, so pc_q+4 and pc_q+8 never wrap to a false "in range".
// - Valid rule: fd_valid_b=1 implies fd_valid_a=1.
// - Reset asserted mid-operation: all state clears immediately (async); first fetch needs start again.
// - start while not IDLE: ignored.
// STRUCTURE
// - Shared typedefs package gets:
//   - enum fetch_ctrl_state_e {IDLE,RUN,STALL,HALT}
//   - localparams FETCH_WIDTH=2, INST_BYTES=4
// - Sub-module sat_counter #(W) (inc amount 0..2, saturating): instantiated twice.
// - Everything else is one always_ff (async rst) plus one always_comb for hold/pc/next-state.
// TESTING
// - reset, start, dec_ready=1, IMEM_BYTES=128 -> pc 0,8,16,...; pair valid 1 cycle later; fd_pc 0,8,...
//   - fetch_cnt=32 after pair 120 is accepted; HALT the cycle after pc_q=128.
// - dec_ready=0 for 3 cycles with pair at fd_pc=16 -> pc output=16 for those cycles; fd_pc=16, valids held.
//   - stall_cnt=3; after release, next pair fd_pc=24.
// - redirect_valid with redirect_pc=32'h43 during RUN -> next cycle fd_valid_a/b=0; pc=0x40.
//   - Following cycle fd_pc=0x40, both valid.
// - redirect and dec_ready=0 in same cycle -> redirect wins: valids 0, stall_cnt unchanged, state RUN.
// - IMEM_BYTES=124, pc reaches 120 -> fd_valid_a=1, fd_valid_b=0; then HALT.
//   - redirect_pc=0 from HALT restarts fetch at 0.
// - rst asserted mid-STALL, between clock edges -> outputs reset without waiting for clk; state IDLE.
//   - start=0 keeps valids 0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the 2-wide fetch controller.
//   fetch_ctrl_state_e : controller FSM states
//   in_imem()          : 33-bit range check so addr+offset never wraps into range
package fetch_ctrl_pkg;

    localparam int unsigned FETCH_WIDTH = 2;
    localparam int unsigned INST_BYTES  = 4;
    localparam int unsigned PAIR_BYTES  = FETCH_WIDTH * INST_BYTES;
    localparam int unsigned XLEN        = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } fetch_ctrl_state_e;

    // True when addr+offset lies below imem_bytes, evaluated without wrap-around.
    function automatic logic in_imem(input logic [XLEN-1:0] addr,
                                     input int unsigned     offset,
                                     input int unsigned     imem_bytes);
        return (33'(addr) + 33'(offset)) < 33'(imem_bytes);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: backend redirect, decode handshake, fetch address and status.
//   master : the controller (drives pc, fetch-register tags, status, counters)
//   slave  : surrounding pipeline / bench (drives start, dec_ready, redirect)
interface fetch_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic                              start;
    logic                              dec_ready;
    logic                              redirect_valid;
    logic [fetch_ctrl_pkg::XLEN-1:0]   redirect_pc;
    logic [fetch_ctrl_pkg::XLEN-1:0]   pc;
    logic                              fd_valid_a;
    logic                              fd_valid_b;
    logic [fetch_ctrl_pkg::XLEN-1:0]   fd_pc;
    logic                              halted;
    logic [CNT_W-1:0]                  fetch_cnt;
    logic [CNT_W-1:0]                  stall_cnt;

    modport master (
        input  start, dec_ready, redirect_valid, redirect_pc,
        output pc, fd_valid_a, fd_valid_b, fd_pc, halted, fetch_cnt, stall_cnt
    );

    modport slave (
        output start, dec_ready, redirect_valid, redirect_pc,
        input  pc, fd_valid_a, fd_valid_b, fd_pc, halted, fetch_cnt, stall_cnt
    );
endinterface

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter, increment 0..2 per cycle, sticks at all-ones.
//   clk, rst : clock, async active-high reset
//   inc      : increment amount this cycle
//   count    : registered count value
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   inc,
    output logic [W-1:0] count
);
    localparam int unsigned SUM_W = W + 1;

    logic [SUM_W-1:0] sum;

    // Extra carry bit flags overflow so the count clamps instead of wrapping.
    always_comb begin
        sum = {1'b0, count} + SUM_W'(inc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (sum[W]) begin
            count <= '1;
        end else begin
            count <= sum[W-1:0];
        end
    end
endmodule

// File: rtl/fetch_ctrl.sv
// 2-wide fetch sequencer: owns the fetch PC, tags the fetch-register pair with valids,
// stalls on decode backpressure, squashes on redirect, halts past end of IMEM.
//   clk, rst : clock, async active-high reset
//   bus      : fetch_ctrl_if master (start/dec_ready/redirect in; pc/fd_*/halted/counters out)
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     IMEM_BYTES = 128,
    parameter int unsigned     CNT_W      = 16
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);
    fetch_ctrl_state_e state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   fd_pc_q, fd_pc_d;
    logic              va_q, va_d;
    logic              vb_q, vb_d;
    logic              hold;
    logic              redirect_eff;
    logic [1:0]        fetch_inc;
    logic [1:0]        stall_inc;

    // Next-state, hold and fetch-address logic; redirect > hold > advance.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fd_pc_d      = fd_pc_q;
        va_d         = va_q;
        vb_d         = vb_q;
        hold         = va_q & ~bus.dec_ready;
        redirect_eff = bus.redirect_valid & (state_q != IDLE);
        fetch_inc    = 2'(va_q & bus.dec_ready) + 2'(vb_q & bus.dec_ready);
        stall_inc    = 2'(hold);

        if (redirect_eff) begin
            // Squash the wrong-path pair; a held pair is dropped uncounted.
            pc_d      = {bus.redirect_pc[XLEN-1:2], 2'b00};
            va_d      = 1'b0;
            vb_d      = 1'b0;
            state_d   = RUN;
            fetch_inc = 2'd0;
            stall_inc = 2'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d = RUN;
                    end
                end
                RUN, STALL: begin
                    if (hold) begin
                        state_d = STALL;
                    end else begin
                        fd_pc_d = pc_q;
                        va_d    = in_imem(pc_q, 0, IMEM_BYTES);
                        vb_d    = in_imem(pc_q, INST_BYTES, IMEM_BYTES);
                        if (in_imem(pc_q, 0, IMEM_BYTES)) begin
                            pc_d    = pc_q + XLEN'(PAIR_BYTES);
                            state_d = RUN;
                        end else begin
                            state_d = HALT;
                        end
                    end
                end
                HALT: begin
                    // Drain the last pair once decode takes it.
                    if (!hold) begin
                        va_d = 1'b0;
                        vb_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Re-present the held pair's address so the fetch register stays stable.
        bus.pc = hold ? fd_pc_q : pc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            fd_pc_q <= RESET_PC;
            va_q    <= 1'b0;
            vb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fd_pc_q <= fd_pc_d;
            va_q    <= va_d;
            vb_q    <= vb_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_fetch_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (fetch_inc),
        .count (bus.fetch_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (bus.stall_cnt)
    );

    assign bus.fd_pc      = fd_pc_q;
    assign bus.fd_valid_a = va_q;
    assign bus.fd_valid_b = vb_q;
    assign bus.halted     = (state_q == HALT);
endmodule
